exec_mem_unit: RTL and testbench

//  Execute/memory slice of the single-cycle RV32I core: instruction decoder (control),
//  32-bit ALU and word-addressed data RAM in one block. Takes the fetched instruction,

---
 rtl/exec_mem_unit.sv | 204 ++++++++++++++++++++
 tb/tb_exec_mem_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// exec_mem_unit: execute/memory slice of a single-cycle RV32I core.
// Combinational decoder and 32-bit ALU feeding a word-addressed data RAM with
// asynchronous read and a synchronous write port. The RAM is the only state.
module exec_mem_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        branch,
  output logic        memread,
  output logic        memtoreg,
  output logic        alusrc,
  output logic        memwrite,
  output logic        regwrite,
  output logic [3:0]  aluctrl,
  output logic [31:0] alu_y,
  output logic        zero,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_data
);

  // Word-index width; the byte address carries two extra low bits.
  localparam int AW = $clog2(MEM_WORDS);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  typedef enum logic [6:0] {
    OPC_RTYPE  = 7'b0110011,
    OPC_ITYPE  = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100
  } alu_op_e;

  // Everything the decoder produces for one instruction.
  typedef struct packed {
    logic    branch;
    logic    memread;
    logic    memtoreg;
    logic    alusrc;
    logic    memwrite;
    logic    regwrite;
    alu_op_e alu_op;
  } ctrl_t;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  opcode_e     opcode;
  logic [2:0]  funct3;
  logic        funct7b5;

  assign opcode   = opcode_e'(instr[6:0]);
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  // Shared funct3 decode for register and immediate arithmetic. Immediate
  // forms have no subtract (funct7b5 there is part of the immediate), while
  // both forms use funct7b5 to pick arithmetic over logical right shift.
  function automatic alu_op_e arith_op(input logic [2:0] f3,
                                       input logic       f7b5,
                                       input logic       is_reg);
    case (f3)
      3'b000:  arith_op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Decoder
  // --------------------------------------------------------------------------
  ctrl_t ctrl;

  // Map opcode/funct fields to control strobes; unknown opcodes decode as a NOP.
  always_comb begin
    // NOTE: every field gets a value before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OPC_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.alu_op   = arith_op(funct3, funct7b5, 1'b1);
      end
      OPC_ITYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.alu_op   = arith_op(funct3, funct7b5, 1'b0);
      end
      OPC_LOAD: begin
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OPC_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign branch   = ctrl.branch;
  assign memread  = ctrl.memread;
  assign memtoreg = ctrl.memtoreg;
  assign alusrc   = ctrl.alusrc;
  assign memwrite = ctrl.memwrite;
  assign regwrite = ctrl.regwrite;
  assign aluctrl  = ctrl.alu_op;

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  assign alu_a = rs1_data;
  assign alu_b = ctrl.alusrc ? imm : rs2_data;
  assign shamt = alu_b[4:0];

  // Compute the selected operation; codes outside the table yield zero.
  always_comb begin
    alu_res = '0;
    case (ctrl.alu_op)
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  assign alu_y = alu_res;
  assign zero  = (alu_res == 32'd0);

  // --------------------------------------------------------------------------
  // Data RAM
  // --------------------------------------------------------------------------
  // Only the word-index bits of the byte address are used: upper bits alias
  // (the address wraps) and the byte offset is ignored.
  logic [AW-1:0] mem_idx;
  assign mem_idx = alu_res[AW+1:2];

  // Power-up contents are zero. This is an initial value, not a reset: the
  // array never appears in a reset branch, so it maps onto plain RAM.
  logic [31:0] mem [MEM_WORDS] = '{default: '0};

  // Store port: commits on the rising edge unless reset is asserted.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset clear; rst_n only gates the write enable so
    // the array stays a plain memory and its contents survive reset.
    if (rst_n && ctrl.memwrite) begin
      // NOTE: non-blocking so every sequential reader sees the pre-edge value.
      mem[mem_idx] <= rs2_data;
    end
  end

  // Asynchronous read; gated to zero unless the instruction is a load.
  assign mem_rdata = ctrl.memread ? mem[mem_idx] : 32'd0;
  assign wb_data   = ctrl.memtoreg ? mem_rdata : alu_res;

  // Instruction and address bits this slice has no use for.
  logic unused_bits;
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7],
                         alu_res[31:AW+2], alu_res[1:0]};

endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: directed and randomized checks of exec_mem_unit against
// an instruction-level reference model kept in the bench.
module tb_exec_mem_unit;

  localparam int MEM_WORDS = 256;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr, rs1_data, rs2_data, imm;
  logic        branch, memread, memtoreg, alusrc, memwrite, regwrite;
  logic [3:0]  aluctrl;
  logic [31:0] alu_y, mem_rdata, wb_data;
  logic        zero;

  exec_mem_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .branch(branch), .memread(memread),
    .memtoreg(memtoreg), .alusrc(alusrc), .memwrite(memwrite),
    .regwrite(regwrite), .aluctrl(aluctrl), .alu_y(alu_y), .zero(zero),
    .mem_rdata(mem_rdata), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instruction encodings used by directed tests (rd=x3, rs1=x1, rs2=x2).
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SRAI = 32'h4040D193;
  localparam logic [31:0] I_SRLI = 32'h0040D193;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_SLTU = 32'h0020B1B3;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_NOP  = 32'h00000000;

  // ---------------------------------------------------------------------------
  // Reference model: mnemonic-level semantics plus a word array for the RAM.
  // ---------------------------------------------------------------------------
  typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND} mn_e;

  typedef struct packed {
    logic        branch, memread, memtoreg, alusrc, memwrite, regwrite;
    logic [3:0]  aluctrl;
    logic [31:0] y;
    logic        zero;
    logic [31:0] rdata;
    logic [31:0] wb;
  } exp_t;

  logic [31:0] ref_mem [MEM_WORDS];
  exp_t        cur_exp;

  function automatic logic [3:0] code_of(input mn_e m);
    case (m)
      M_AND:  return 4'h0;
      M_OR:   return 4'h1;
      M_ADD:  return 4'h2;
      M_SUB:  return 4'h6;
      M_SLT:  return 4'h7;
      M_SLTU: return 4'h8;
      M_XOR:  return 4'h9;
      M_SLL:  return 4'hA;
      M_SRL:  return 4'hB;
      default: return 4'hC;
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] byte_addr);
    return int'((byte_addr >> 2) % MEM_WORDS);
  endfunction

  function automatic exp_t model(input logic [31:0] ins, a, rs2, im);
    exp_t        e;
    mn_e         m;
    logic [31:0] b;
    int          sh;
    int          sa, sb;
    mn_e         f3_tbl [8];
    f3_tbl = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
    e = '0;
    m = M_ADD;
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      e.regwrite = 1'b1;
      e.alusrc   = (ins[6:0] == 7'h13);
      m = f3_tbl[ins[14:12]];
      if (ins[14:12] == 3'd5 && ins[30]) m = M_SRA;
      if (ins[14:12] == 3'd0 && ins[30] && ins[6:0] == 7'h33) m = M_SUB;
    end else if (ins[6:0] == 7'h03) begin
      e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1; e.alusrc = 1'b1;
    end else if (ins[6:0] == 7'h23) begin
      e.memwrite = 1'b1; e.alusrc = 1'b1;
    end else if (ins[6:0] == 7'h63) begin
      e.branch = 1'b1; m = M_SUB;
    end
    b  = e.alusrc ? im : rs2;
    sh = int'(b[4:0]);
    sa = a;
    sb = b;
    case (m)
      M_ADD:  e.y = a + b;
      M_SUB:  e.y = a - b;
      M_SLL:  e.y = a << sh;
      M_SLT:  e.y = (sa < sb) ? 32'd1 : 32'd0;
      M_SLTU: e.y = (a < b) ? 32'd1 : 32'd0;
      M_XOR:  e.y = a ^ b;
      M_SRL:  e.y = a >> sh;
      M_SRA:  e.y = sa >>> sh;
      M_OR:   e.y = a | b;
      default: e.y = a & b;
    endcase
    e.aluctrl = code_of(m);
    e.zero    = (e.y == 32'd0);
    e.rdata   = e.memread ? ref_mem[word_of(e.y)] : 32'd0;
    e.wb      = e.memtoreg ? e.rdata : e.y;
    return e;
  endfunction

  // Apply one instruction for one clock cycle. The previous instruction has
  // just been through a rising edge, so its store (if any) lands in the model
  // first. Outputs are settled and stable 2 time units after the falling edge.
  task automatic drive(input logic r, input logic [31:0] i, a, b, im);
    @(negedge clk);
    if (rst_n && cur_exp.memwrite) ref_mem[word_of(cur_exp.y)] = rs2_data;
    rst_n    = r;
    instr    = i;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    cur_exp  = model(i, a, b, im);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b0, I_SW, 32'd4, 32'hCAFEF00D, 32'd0);
    n_checks++;
    if (memwrite !== 1'b1 || alu_y !== 32'd4) begin
      n_errors++;
      $display("FAIL reset_comb: memwrite=%b alu_y=%h, expected 1 / 00000004", memwrite, alu_y);
    end
    drive(1'b0, I_SW, 32'd4, 32'hCAFEF00D, 32'd0);
    drive(1'b1, I_LW, 32'd4, 32'h0, 32'd0);
    n_checks++;
    if (mem_rdata !== 32'd0 || wb_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_no_write: rdata=%h wb=%h, expected 0", mem_rdata, wb_data);
    end
  endtask

  task automatic test_add();
    drive(1'b1, I_ADD, 32'd5, 32'd7, 32'd0);
    n_checks++;
    if ({regwrite, alusrc, aluctrl} !== {1'b1, 1'b0, 4'b0010}) begin
      n_errors++;
      $display("FAIL add_ctrl: regwrite/alusrc/aluctrl=%b, expected 1_0_0010", {regwrite, alusrc, aluctrl});
    end
    n_checks++;
    if (alu_y !== 32'd12 || zero !== 1'b0 || wb_data !== 32'd12) begin
      n_errors++;
      $display("FAIL add_y: y=%h zero=%b wb=%h, expected 0000000c 0 0000000c", alu_y, zero, wb_data);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, I_BEQ, 32'h1234, 32'h1234, 32'h40);
    n_checks++;
    if (branch !== 1'b1 || aluctrl !== 4'b0110 || zero !== 1'b1) begin
      n_errors++;
      $display("FAIL beq_taken: branch=%b aluctrl=%b zero=%b, expected 1 0110 1", branch, aluctrl, zero);
    end
    drive(1'b1, I_BEQ, 32'h1234, 32'h1235, 32'h40);
    n_checks++;
    if (zero !== 1'b0 || alu_y !== 32'hFFFFFFFF) begin
      n_errors++;
      $display("FAIL beq_not_taken: zero=%b y=%h, expected 0 ffffffff", zero, alu_y);
    end
  endtask

  task automatic test_shift_compare();
    logic [31:0] exp_y [4];
    logic [31:0] ins   [4];
    logic [31:0] a     [4];
    logic [31:0] b     [4];
    ins   = '{I_SRAI, I_SRLI, I_SLT, I_SLTU};
    a     = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    b     = '{32'h0, 32'h0, 32'd1, 32'd1};
    exp_y = '{32'hF8000000, 32'h08000000, 32'd1, 32'd0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ins[k], a[k], b[k], 32'd4);
      n_checks++;
      if (alu_y !== exp_y[k]) begin
        n_errors++;
        $display("FAIL shift_cmp_%0d: y=%h, expected %h", k, alu_y, exp_y[k]);
      end
    end
  endtask

  task automatic test_mem();
    drive(1'b1, I_SW, 32'd8, 32'hDEADBEEF, 32'd0);
    n_checks++;
    if (memwrite !== 1'b1 || regwrite !== 1'b0 || mem_rdata !== 32'd0) begin
      n_errors++;
      $display("FAIL sw_ctrl: memwrite=%b regwrite=%b rdata=%h, expected 1 0 0", memwrite, regwrite, mem_rdata);
    end
    drive(1'b1, I_LW, 32'd8, 32'h0, 32'd0);
    n_checks++;
    if (mem_rdata !== 32'hDEADBEEF || wb_data !== 32'hDEADBEEF || memtoreg !== 1'b1) begin
      n_errors++;
      $display("FAIL lw_8: rdata=%h wb=%h memtoreg=%b, expected deadbeef deadbeef 1", mem_rdata, wb_data, memtoreg);
    end
    drive(1'b1, I_LW, 32'h400, 32'h0, 32'd8);
    n_checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL lw_wrap: rdata=%h, expected deadbeef", mem_rdata);
    end
    drive(1'b0, I_NOP, 32'h0, 32'h0, 32'h0);
    drive(1'b0, I_NOP, 32'h0, 32'h0, 32'h0);
    drive(1'b1, I_LW, 32'd8, 32'h0, 32'd0);
    n_checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL lw_after_reset: rdata=%h, expected deadbeef", mem_rdata);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, I_ILL, 32'd8, 32'h0, 32'd0);
    n_checks++;
    if ({branch, memread, memtoreg, alusrc, memwrite, regwrite} !== 6'b0 || aluctrl !== 4'b0010) begin
      n_errors++;
      $display("FAIL illegal_ctrl: strobes=%b aluctrl=%b, expected 000000 0010",
               {branch, memread, memtoreg, alusrc, memwrite, regwrite}, aluctrl);
    end
    drive(1'b1, I_LW, 32'd8, 32'h0, 32'd0);
    n_checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL illegal_no_write: rdata=%h, expected deadbeef", mem_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, addr;
    for (int k = 0; k < 8; k++) begin
      d    = $urandom;
      addr = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      drive(1'b1, I_SW, addr, d, 32'd0);
      drive(1'b1, I_LW, addr, 32'h0, 32'd0);
      n_checks++;
      if (mem_rdata !== d || wb_data !== d) begin
        n_errors++;
        $display("FAIL b2b_%0d: rdata=%h wb=%h, expected %h", k, mem_rdata, wb_data, d);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [5];
    logic [31:0] i, a, b, im;
    logic        r;
    int          sel;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 5);
      i   = $urandom;
      a   = $urandom;
      b   = $urandom;
      im  = $urandom;
      if (sel < 5) begin
        i[6:0] = opcs[sel];
      end else begin
        while (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63}) i[6:0] = 7'($urandom);
      end
      if (sel == 2 || sel == 3) begin
        a  = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2);
        im = 32'($urandom_range(0, 3));
      end
      if (sel == 4 && $urandom_range(0, 1) == 1) b = a;
      if (sel == 1 && $urandom_range(0, 1) == 1) im = 32'($signed(im[11:0]));
      r = ($urandom_range(0, 19) != 0);
      drive(r, i, a, b, im);
      n_checks++;
      if ({branch, memread, memtoreg, alusrc, memwrite, regwrite, aluctrl} !==
          {cur_exp.branch, cur_exp.memread, cur_exp.memtoreg, cur_exp.alusrc,
           cur_exp.memwrite, cur_exp.regwrite, cur_exp.aluctrl}) begin
        n_errors++;
        $display("FAIL rnd_ctrl[%0d] instr=%h: got %b, expected %b", k, i,
                 {branch, memread, memtoreg, alusrc, memwrite, regwrite, aluctrl},
                 {cur_exp.branch, cur_exp.memread, cur_exp.memtoreg, cur_exp.alusrc,
                  cur_exp.memwrite, cur_exp.regwrite, cur_exp.aluctrl});
      end
      n_checks++;
      if (alu_y !== cur_exp.y || zero !== cur_exp.zero) begin
        n_errors++;
        $display("FAIL rnd_alu[%0d] instr=%h: y=%h zero=%b, expected %h %b", k, i,
                 alu_y, zero, cur_exp.y, cur_exp.zero);
      end
      n_checks++;
      if (mem_rdata !== cur_exp.rdata || wb_data !== cur_exp.wb) begin
        n_errors++;
        $display("FAIL rnd_mem[%0d] instr=%h: rdata=%h wb=%h, expected %h %h", k, i,
                 mem_rdata, wb_data, cur_exp.rdata, cur_exp.wb);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) ref_mem[w] = 32'd0;
    rst_n    = 1'b0;
    instr    = I_NOP;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    imm      = 32'd0;
    cur_exp  = model(I_NOP, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_add();
    test_branch();
    test_shift_compare();
    test_mem();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
